mul_seq: RTL and testbench

- Sequencer for the MIX MUL instruction. It sits directly upstream of the 30x30 `mul` unit and also consumes that unit's product.
- Extracts field V from the fetched memory word using the (L:R) spec and drives `mul` with the magnitudes of rA and V.
- Pulses `mul` start, waits out the fixed multiplier latency, then writes the signed 60-bit product back as rA (high word) and rX (low word).

---
 rtl/mul_seq.sv | 152 +++++++++++++++
 tb/tb_mul_seq.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq.sv
// mul_seq: sequencer for the MIX MUL instruction.
// Extracts field V of the memory word, drives the external 30x30 `mul` unit
// with |rA| and |V|, waits out the multiplier latency and writes the signed
// 60-bit product back as rA (high word) and rX (low word).
// Optional feature: define MUL_ZERO_BYPASS_EN to skip the multiplier when
// either operand is zero (the written result is identical either way).
module mul_seq #(
  parameter int START_CYCLES = 3,
  parameter int MUL_LAT      = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic [5:0]  f,
  input  logic [30:0] ra_in,
  input  logic [30:0] mem_in,
  output logic        mul_start,
  output logic [29:0] mul_a,
  output logic [29:0] mul_b,
  input  logic [59:0] mul_out,
  output logic [30:0] ra_out,
  output logic [30:0] rx_out,
  output logic        we,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int CW = $clog2(MUL_LAT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] c;
  logic [CW-1:0] c_next;
  logic          ps;
  logic [2:0]    fl;
  logic [2:0]    fr;
  logic          f_valid;
  logic [29:0]   v_mag;
  logic          v_sign;
  logic          go_ps;
`ifdef MUL_ZERO_BYPASS_EN
  logic          zbyp;
`endif

  // Magnitude of field (l:r): bytes max(l,1)..r right-justified, upper bits zero.
  function automatic logic [29:0] field_mag(input logic [29:0] m,
                                            input logic [2:0]  l,
                                            input logic [2:0]  r);
    logic [2:0]  lo;
    logic [29:0] sh;
    logic [29:0] mask;
    lo = (l == 3'd0) ? 3'd1 : l;
    if (r == 3'd0) return 30'd0;
    sh   = m >> (6 * (5 - int'(r)));
    // a full 5-byte field shifts the 1 out, leaving an all-ones mask after -1
    mask = (30'd1 << (6 * (int'(r) - int'(lo) + 1))) - 30'd1;
    return sh & mask;
  endfunction

  assign fl      = f[5:3];
  assign fr      = f[2:0];
  assign f_valid = (fr <= 3'd5) && (fl <= fr);
  assign v_mag   = field_mag(mem_in[29:0], fl, fr);
  // Only a field that includes byte 0 carries the memory sign
  assign v_sign  = (fl == 3'd0) ? mem_in[30] : 1'b0;
  assign go_ps   = ra_in[30] ^ v_sign;
  assign c_next  = c + CW'(1);

  // Control FSM with registered outputs: accept, run the multiplier, write back
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      c         <= '0;
      ps        <= 1'b0;
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      ra_out    <= '0;
      rx_out    <= '0;
      we        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
`ifdef MUL_ZERO_BYPASS_EN
      zbyp      <= 1'b0;
`endif
    end else begin
      we   <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            if (!f_valid) begin
              err <= 1'b1;
            end else begin
              mul_a <= ra_in[29:0];
              mul_b <= v_mag;
              ps    <= go_ps;
              c     <= '0;
              busy  <= 1'b1;
`ifdef MUL_ZERO_BYPASS_EN
              if ((ra_in[29:0] == 30'd0) || (v_mag == 30'd0)) begin
                zbyp  <= 1'b1;
                state <= WB;
              end else begin
                zbyp      <= 1'b0;
                mul_start <= 1'b1;
                state     <= RUN;
              end
`else
              mul_start <= 1'b1;
              state     <= RUN;
`endif
            end
          end
        end
        RUN: begin
          c         <= c_next;
          mul_start <= (int'(c_next) < START_CYCLES);
          if (c == CW'(MUL_LAT - 1)) state <= WB;
        end
        WB: begin
`ifdef MUL_ZERO_BYPASS_EN
          ra_out <= {ps, zbyp ? 30'd0 : mul_out[59:30]};
          rx_out <= {ps, zbyp ? 30'd0 : mul_out[29:0]};
`else
          ra_out <= {ps, mul_out[59:30]};
          rx_out <= {ps, mul_out[29:0]};
`endif
          we        <= 1'b1;
          done      <= 1'b1;
          busy      <= 1'b0;
          mul_start <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state     <= IDLE;
          mul_start <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Bench for mul_seq: a model of the `mul` unit, a cycle-level behavioural
// reference of the sequencer, a per-cycle compare process and directed cases.
module tb_mul_seq;

  localparam int START_CYCLES = 3;
  localparam int MUL_LAT      = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic        go;
  logic [5:0]  f;
  logic [30:0] ra_in;
  logic [30:0] mem_in;
  logic        mul_start;
  logic [29:0] mul_a;
  logic [29:0] mul_b;
  logic [59:0] mul_out;
  logic [30:0] ra_out;
  logic [30:0] rx_out;
  logic        we;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  bit chk_en = 1'b0;

  mul_seq #(.START_CYCLES(START_CYCLES), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .reset(reset), .go(go), .f(f), .ra_in(ra_in), .mem_in(mem_in),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out),
    .ra_out(ra_out), .rx_out(rx_out), .we(we), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model of the `mul` unit: junk until MUL_LAT cycles after the first start cycle
  int          mcnt = 0;
  bit          mstart_q = 1'b0;
  logic [59:0] mprod = '0;
  always @(posedge clk) begin
    if (mul_start === 1'b1 && !mstart_q) begin
      mcnt  = 1;
      mprod = mul_a * mul_b;
    end else if (mcnt != 0 && mcnt < 1000) begin
      mcnt++;
    end
    mstart_q = (mul_start === 1'b1);
    mul_out <= (mcnt >= MUL_LAT) ? mprod : {28'($urandom), $urandom};
  end

  // Behavioural reference: one outstanding op, timed from its accepting edge
  int          cyc = 0;
  int          k = 0;
  bit          op_active = 1'b0;
  bit          byp = 1'b0;
  bit          m_ps = 1'b0;
  logic [59:0] m_prod = '0;
  logic        exp_ms, exp_we, exp_done, exp_err, exp_busy;
  logic [29:0] exp_a, exp_b;
  logic [30:0] exp_ra, exp_rx;

  always @(posedge clk) begin
    int  l, r, lo;
    bit  vs;
    longint a, v;
    cyc++;
    if (reset) begin
      op_active = 1'b0;
      exp_ms = 0; exp_we = 0; exp_done = 0; exp_err = 0; exp_busy = 0;
      exp_a = '0; exp_b = '0; exp_ra = '0; exp_rx = '0;
    end else begin
      exp_we = 0; exp_done = 0; exp_err = 0;
      if (op_active) begin
        if (cyc - k == (byp ? 1 : MUL_LAT + 1)) begin
          exp_ra    = {m_ps, m_prod[59:30]};
          exp_rx    = {m_ps, m_prod[29:0]};
          exp_we    = 1;
          exp_done  = 1;
          op_active = 1'b0;
        end
      end else if (go) begin
        l = int'(f[5:3]);
        r = int'(f[2:0]);
        if (r > 5 || l > r) begin
          exp_err = 1;
        end else begin
          lo = (l == 0) ? 1 : l;
          v  = 0;
          for (int i = lo; i <= r; i++) v = v * 64 + longint'(mem_in[35 - 6 * i -: 6]);
          vs = (l == 0) ? mem_in[30] : 1'b0;
          a  = longint'(ra_in[29:0]);
          m_ps   = ra_in[30] ^ vs;
          m_prod = 60'(a * v);
          exp_a  = a[29:0];
          exp_b  = v[29:0];
`ifdef MUL_ZERO_BYPASS_EN
          byp = (a == 0) || (v == 0);
`else
          byp = 1'b0;
`endif
          op_active = 1'b1;
          k = cyc;
        end
      end
      exp_ms   = op_active && !byp && (cyc - k) < START_CYCLES;
      exp_busy = op_active;
    end
  end

  // Per-cycle comparison of every output against the reference
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (chk_en) begin
      chk("mul_start", 64'(mul_start), 64'(exp_ms));
      chk("we", 64'(we), 64'(exp_we));
      chk("done", 64'(done), 64'(exp_done));
      chk("err", 64'(err), 64'(exp_err));
      if (!exp_done) chk("busy", 64'(busy), 64'(exp_busy));
      chk("mul_a", 64'(mul_a), 64'(exp_a));
      chk("mul_b", 64'(mul_b), 64'(exp_b));
      chk("ra_out", 64'(ra_out), 64'(exp_ra));
      chk("rx_out", 64'(rx_out), 64'(exp_rx));
    end
  end

  // Issue one op and count cycles from go until done
  task automatic do_op(input logic [30:0] ra, input logic [30:0] mem, input logic [5:0] ff,
                       output int lat);
    @(negedge clk);
    ra_in = ra; mem_in = mem; f = ff; go = 1'b1;
    @(negedge clk);
    go = 1'b0; ra_in = 31'($urandom); mem_in = 31'($urandom); f = 6'($urandom);
    lat = 1;
    while (done !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (done !== 1'b1) begin
      checks++; errors++;
      $display("FAIL op_timeout: got no done after %0d cycles", lat);
    end
  endtask

  task automatic do_bad(input logic [5:0] ff);
    @(negedge clk);
    ra_in = 31'($urandom); mem_in = 31'($urandom); f = ff; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    chk("bad_err_pulse", 64'(err), 64'd1);
    chk("bad_busy", 64'(busy), 64'd0);
    chk("bad_start", 64'(mul_start), 64'd0);
    @(negedge clk);
    chk("bad_err_clear", 64'(err), 64'd0);
    chk("bad_we", 64'(we), 64'd0);
  endtask

  initial begin
    int lat;
    int d0;
    logic [30:0] mem_bytes;
    logic [59:0] lp;
    reset = 1'b1; go = 1'b0; f = '0; ra_in = '0; mem_in = '0;
    repeat (2) @(negedge clk);
    chk("reset_ra_out", 64'(ra_out), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_mul_a", 64'(mul_a), 64'd0);
    reset = 1'b0;
    chk_en = 1'b1;

    // Basic: -2 * +3 over (0:5)
    do_op({1'b1, 30'd2}, {1'b0, 30'd3}, 6'd5, lat);
    chk("basic_latency", 64'(lat), 64'(MUL_LAT + 2));
    chk("basic_mul_a", 64'(mul_a), 64'd2);
    chk("basic_mul_b", 64'(mul_b), 64'd3);
    chk("basic_ra", 64'(ra_out), 64'h4000_0000);
    chk("basic_rx", 64'(rx_out), 64'h4000_0006);

    // Field extraction from bytes 1,2,3,4,5 with sign minus
    mem_bytes = {1'b1, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5};
    do_op({1'b0, 30'd1}, mem_bytes, 6'd10, lat);
    chk("field_12_mul_b", 64'(mul_b), 64'd66);
    chk("field_12_sign", 64'(ra_out[30]), 64'd0);
    do_op({1'b0, 30'd1}, mem_bytes, 6'd1, lat);
    chk("field_01_mul_b", 64'(mul_b), 64'd1);
    chk("field_01_sign", 64'(rx_out[30]), 64'd1);
    chk("field_01_rx", 64'(rx_out), 64'h4000_0001);

    // Large operands
    lp = 60'd185595198769359756;
    do_op({1'b0, 30'd792348734}, {1'b0, 30'd234234234}, 6'd5, lat);
    chk("large_ra", 64'(ra_out), 64'({1'b0, lp[59:30]}));
    chk("large_rx", 64'(rx_out), 64'({1'b0, lp[29:0]}));

    // Invalid fields
    do_bad(6'd26);
    do_bad(6'd6);

    // Second go while busy is ignored
    d0 = done_cnt;
    @(negedge clk);
    ra_in = {1'b0, 30'd3}; mem_in = {1'b0, 30'd4}; f = 6'd5; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (3) @(negedge clk);
    ra_in = {1'b1, 30'd9}; mem_in = {1'b0, 30'd9}; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (MUL_LAT + 6) @(negedge clk);
    chk("busy_go_one_done", 64'(done_cnt - d0), 64'd1);
    chk("busy_go_rx", 64'(rx_out), 64'd12);

    // Zero operand: -0 memory, +7 rA
    do_op({1'b0, 30'd7}, {1'b1, 30'd0}, 6'd5, lat);
`ifdef MUL_ZERO_BYPASS_EN
    chk("zero_latency", 64'(lat), 64'd2);
`else
    chk("zero_latency", 64'(lat), 64'(MUL_LAT + 2));
`endif
    chk("zero_ra", 64'(ra_out), 64'h4000_0000);
    chk("zero_rx", 64'(rx_out), 64'h4000_0000);

    // Reset mid-RUN at c = 4
    @(negedge clk);
    ra_in = {1'b0, 30'd5}; mem_in = {1'b0, 30'd5}; f = 6'd5; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    d0 = done_cnt;
    @(negedge clk);
    chk("rst_mul_start", 64'(mul_start), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_ra_out", 64'(ra_out), 64'd0);
    chk("rst_rx_out", 64'(rx_out), 64'd0);
    chk("rst_mul_ab", 64'({mul_a, mul_b}), 64'd0);
    repeat (MUL_LAT + 4) @(negedge clk);
    chk("rst_no_done", 64'(done_cnt - d0), 64'd0);

    // Randomized traffic against the reference
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      go     = ($urandom_range(0, 3) == 0);
      ra_in  = ($urandom_range(0, 7) == 0) ? {1'($urandom), 30'd0} : 31'($urandom);
      mem_in = ($urandom_range(0, 7) == 0) ? {1'($urandom), 30'd0} : 31'($urandom);
      f      = {3'($urandom_range(0, 5)), 3'($urandom_range(0, 6))};
    end
    @(negedge clk);
    go = 1'b0;
    repeat (MUL_LAT + 4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
